// File: rtl/pwm_dac_subsystem.sv
// PWM DAC output path: duty code from a valid/ready shadow register or an internal
// sawtooth/triangle sweep, applied only at PWM period boundaries.
module pwm_dac_subsystem #(
   parameter int WIDTH            = 8,
   parameter int STEP             = 1,
   parameter int PERIODS_PER_STEP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] dac_code_out
);
   localparam int SCW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam logic [WIDTH-1:0] CODE_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CODE_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
   localparam logic [SCW-1:0] SC_LAST = SCW'(PERIODS_PER_STEP - 1);
   localparam logic [SCW-1:0] SC_ZERO = {SCW{1'b0}};

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_EXT    = 3'd1,
      ST_SAW    = 3'd2,
      ST_TRI_UP = 3'd3,
      ST_TRI_DN = 3'd4
   } state_t;

   state_t           state_r, state_n_s;
   logic [WIDTH-1:0] cnt_r, cnt_n_s;
   logic [WIDTH-1:0] duty_r, duty_n_s;
   logic [WIDTH-1:0] shadow_r, shadow_n_s;
   logic [WIDTH-1:0] sweep_r, sweep_n_s;
   logic [WIDTH-1:0] dac_r, dac_n_s;
   logic [SCW-1:0]   step_cnt_r, step_cnt_n_s;
   logic             full_r, full_n_s;
   logic             ready_r, ready_n_s;
   logic             pwm_r, pwm_n_s;
   logic             pstart_r;
   logic             boundary_s, accept_s, sweep_tick_s;
   logic [WIDTH:0]   sweep_sum_s;

   // Next-state logic: counter, handshake, mode sampling and sweep updates
   always_comb begin
      state_n_s    = state_r;
      duty_n_s     = duty_r;
      sweep_n_s    = sweep_r;
      step_cnt_n_s = step_cnt_r;
      dac_n_s      = dac_r;
      shadow_n_s   = shadow_r;
      full_n_s     = full_r;
      accept_s     = code_valid && ready_r && (mode == 2'b00);
      // Leaving OFF is itself a boundary so the first period starts at once
      boundary_s   = (state_r == ST_OFF) ? (mode != 2'b11) : (cnt_r == CODE_MAX);
      sweep_tick_s = (step_cnt_r == SC_LAST);
      sweep_sum_s  = {1'b0, sweep_r} + STEP_X;

      if (state_r == ST_OFF) begin
         cnt_n_s = CODE_ZERO;
      end else begin
         cnt_n_s = cnt_r + WIDTH'(1);
      end

      if (accept_s) begin
         shadow_n_s = code_in;
         full_n_s   = 1'b1;
      end else begin
         shadow_n_s = shadow_r;
      end

      if (boundary_s) begin
         case (mode)
            2'b00: begin
               state_n_s = ST_EXT;
               if (full_r) begin
                  duty_n_s = shadow_r;
                  full_n_s = 1'b0;
               end else begin
                  duty_n_s = duty_r;
               end
            end
            2'b01: begin
               if (state_r != ST_SAW) begin
                  state_n_s    = ST_SAW;
                  sweep_n_s    = CODE_ZERO;
                  step_cnt_n_s = SC_ZERO;
                  duty_n_s     = CODE_ZERO;
               end else if (sweep_tick_s) begin
                  sweep_n_s    = sweep_sum_s[WIDTH-1:0];
                  duty_n_s     = sweep_sum_s[WIDTH-1:0];
                  step_cnt_n_s = SC_ZERO;
               end else begin
                  step_cnt_n_s = step_cnt_r + SCW'(1);
               end
            end
            2'b10: begin
               if ((state_r != ST_TRI_UP) && (state_r != ST_TRI_DN)) begin
                  state_n_s    = ST_TRI_UP;
                  sweep_n_s    = CODE_ZERO;
                  step_cnt_n_s = SC_ZERO;
                  duty_n_s     = CODE_ZERO;
               end else if (sweep_tick_s) begin
                  step_cnt_n_s = SC_ZERO;
                  case (state_r)
                     ST_TRI_UP: begin
                        if (sweep_sum_s >= {1'b0, CODE_MAX}) begin
                           sweep_n_s = CODE_MAX;
                           state_n_s = ST_TRI_DN;
                        end else begin
                           sweep_n_s = sweep_sum_s[WIDTH-1:0];
                        end
                     end
                     ST_TRI_DN: begin
                        if (sweep_r <= STEP_W) begin
                           sweep_n_s = CODE_ZERO;
                           state_n_s = ST_TRI_UP;
                        end else begin
                           sweep_n_s = sweep_r - STEP_W;
                        end
                     end
                     default: begin
                        sweep_n_s = CODE_ZERO;
                        state_n_s = ST_TRI_UP;
                     end
                  endcase
                  duty_n_s = sweep_n_s;
               end else begin
                  step_cnt_n_s = step_cnt_r + SCW'(1);
               end
            end
            default: begin
               state_n_s = ST_OFF;
            end
         endcase
         dac_n_s = (state_n_s == ST_OFF) ? CODE_ZERO : duty_n_s;
      end else begin
         dac_n_s = dac_r;
      end

      ready_n_s = (mode == 2'b00) && !full_n_s;
      pwm_n_s   = (state_n_s != ST_OFF) && (cnt_n_s < duty_n_s);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_OFF;
         cnt_r      <= CODE_ZERO;
         duty_r     <= CODE_ZERO;
         shadow_r   <= CODE_ZERO;
         sweep_r    <= CODE_ZERO;
         dac_r      <= CODE_ZERO;
         step_cnt_r <= SC_ZERO;
         full_r     <= 1'b0;
         ready_r    <= 1'b1;
         pwm_r      <= 1'b0;
         pstart_r   <= 1'b0;
      end else begin
         state_r    <= state_n_s;
         cnt_r      <= cnt_n_s;
         duty_r     <= duty_n_s;
         shadow_r   <= shadow_n_s;
         sweep_r    <= sweep_n_s;
         dac_r      <= dac_n_s;
         step_cnt_r <= step_cnt_n_s;
         full_r     <= full_n_s;
         ready_r    <= ready_n_s;
         pwm_r      <= pwm_n_s;
         pstart_r   <= (state_r != ST_OFF) && (cnt_r == CODE_ZERO);
      end
   end

   assign code_ready   = ready_r;
   assign pwm_out      = pwm_r;
   assign period_start = pstart_r;
   assign dac_code_out = dac_r;

endmodule

// File: tb/tb_pwm_dac_subsystem.sv
// Directed bench for pwm_dac_subsystem: external handshake, duty extremes,
// asynchronous reset, OFF mode and both sweep shapes.
module tb_pwm_dac_subsystem;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] code_in;
   logic       code_valid;
   logic [1:0] mode_a, mode_s, mode_t;
   logic       ready_a, pwm_a, ps_a;
   logic       ready_s, pwm_s, ps_s;
   logic       ready_t, pwm_t, ps_t;
   logic [7:0] dac_a, dac_s, dac_t;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int highs, pulses;

   logic [7:0] exp_saw [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0};
   logic [7:0] exp_tri [8] = '{8'h00, 8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};

   pwm_dac_subsystem #(.WIDTH(8), .STEP(1), .PERIODS_PER_STEP(4)) dut_a (
      .clk(clk), .reset(reset), .mode(mode_a), .code_in(code_in), .code_valid(code_valid),
      .code_ready(ready_a), .pwm_out(pwm_a), .period_start(ps_a), .dac_code_out(dac_a));

   pwm_dac_subsystem #(.WIDTH(8), .STEP(8'h40), .PERIODS_PER_STEP(1)) dut_s (
      .clk(clk), .reset(reset), .mode(mode_s), .code_in(code_in), .code_valid(code_valid),
      .code_ready(ready_s), .pwm_out(pwm_s), .period_start(ps_s), .dac_code_out(dac_s));

   pwm_dac_subsystem #(.WIDTH(8), .STEP(8'h60), .PERIODS_PER_STEP(1)) dut_t (
      .clk(clk), .reset(reset), .mode(mode_t), .code_in(code_in), .code_valid(code_valid),
      .code_ready(ready_t), .pwm_out(pwm_t), .period_start(ps_t), .dac_code_out(dac_t));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic measure(input int n, output int h, output int p);
      h = 0;
      p = 0;
      for (int i = 0; i < n; i++) begin
         h += int'(pwm_a);
         p += int'(ps_a);
         ticks(1);
      end
   endtask

   initial begin
      reset      = 1'b0;
      mode_a     = 2'b00;
      mode_s     = 2'b11;
      mode_t     = 2'b11;
      code_in    = 8'h00;
      code_valid = 1'b0;
      ticks(3);
      check("rst_ready", ready_a, 1'b1);
      check("rst_pwm", pwm_a, 1'b0);
      check("rst_pstart", ps_a, 1'b0);
      check("rst_dac", dac_a, 8'h00);

      // 0x80 accepted on the edge that leaves OFF; applies one period later
      reset      = 1'b1;
      code_in    = 8'h80;
      code_valid = 1'b1;
      ticks(1);
      code_valid = 1'b0;
      check("h80_ready_low", ready_a, 1'b0);
      check("h80_dac_first", dac_a, 8'h00);
      ticks(255);
      check("h80_dac_before", dac_a, 8'h00);
      check("h80_ready_full", ready_a, 1'b0);
      ticks(1);
      check("h80_dac", dac_a, 8'h80);
      check("h80_ready_back", ready_a, 1'b1);
      ticks(1);
      check("h80_pstart", ps_a, 1'b1);
      measure(256, highs, pulses);
      check("h80_highs", highs, 128);
      check("h80_pulses", pulses, 1);

      // Duty 0x00
      code_in    = 8'h00;
      code_valid = 1'b1;
      ticks(1);
      code_valid = 1'b0;
      ticks(254);
      check("h00_dac", dac_a, 8'h00);
      ticks(1);
      measure(256, highs, pulses);
      check("h00_highs", highs, 0);

      // Duty 0xFF
      code_in    = 8'hFF;
      code_valid = 1'b1;
      ticks(1);
      code_valid = 1'b0;
      ticks(254);
      check("hff_dac", dac_a, 8'hFF);
      ticks(1);
      measure(256, highs, pulses);
      check("hff_highs", highs, 255);

      // Valid held high, one code per period
      code_in    = 8'h10;
      code_valid = 1'b1;
      ticks(1);
      code_in = 8'h20;
      check("seq_ready_full1", ready_a, 1'b0);
      ticks(254);
      check("seq_dac10", dac_a, 8'h10);
      check("seq_ready_free1", ready_a, 1'b1);
      ticks(1);
      check("seq_ready_full2", ready_a, 1'b0);
      check("seq_dac10_hold", dac_a, 8'h10);
      code_in = 8'h30;
      ticks(255);
      check("seq_dac20", dac_a, 8'h20);
      check("seq_ready_free2", ready_a, 1'b1);
      ticks(1);
      code_valid = 1'b0;
      ticks(255);
      check("seq_dac30", dac_a, 8'h30);
      ticks(255);
      check("seq_dac30_nodup", dac_a, 8'h30);
      check("seq_ready_idle", ready_a, 1'b1);

      // Transfer coinciding with a boundary applies one period later
      code_in    = 8'hC8;
      code_valid = 1'b1;
      ticks(1);
      code_valid = 1'b0;
      check("coinc_dac_hold", dac_a, 8'h30);
      check("coinc_ready_low", ready_a, 1'b0);
      ticks(256);
      check("coinc_dac", dac_a, 8'hC8);

      // Full shadow then reset mid-period at cnt=100
      code_in    = 8'h55;
      code_valid = 1'b1;
      ticks(1);
      code_valid = 1'b0;
      ticks(99);
      check("pre_rst_pwm", pwm_a, 1'b1);
      check("pre_rst_dac", dac_a, 8'hC8);
      check("pre_rst_ready", ready_a, 1'b0);
      #2;
      reset  = 1'b0;
      mode_a = 2'b11;
      #1;
      check("async_pwm", pwm_a, 1'b0);
      check("async_dac", dac_a, 8'h00);
      check("async_ready", ready_a, 1'b1);
      ticks(3);
      reset = 1'b1;
      measure(300, highs, pulses);
      check("off_highs", highs, 0);
      check("off_pulses", pulses, 0);
      check("off_dac", dac_a, 8'h00);
      check("off_ready", ready_a, 1'b0);

      // Back to EXT: discarded shadow code must never reach the output
      mode_a = 2'b00;
      ticks(1);
      measure(520, highs, pulses);
      check("ext_after_rst_highs", highs, 0);
      check("ext_after_rst_pulses", pulses, 3);
      check("ext_after_rst_dac", dac_a, 8'h00);
      check("ext_after_rst_ready", ready_a, 1'b1);

      // Sawtooth (STEP 0x40) and triangle (STEP 0x60), one update per period
      mode_s = 2'b01;
      mode_t = 2'b10;
      ticks(1);
      check("sweep_ready_t", ready_t, 1'b0);
      check("saw_0", dac_s, exp_saw[0]);
      check("tri_0", dac_t, exp_tri[0]);
      for (int k = 1; k < 8; k++) begin
         ticks(256);
         check($sformatf("saw_%0d", k), dac_s, exp_saw[k]);
         check($sformatf("tri_%0d", k), dac_t, exp_tri[k]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
